// File: rtl/cpu_0_mulx_pkg.sv
// Shared definitions for the cpu_0 multi-cycle multiply sequencer:
// op encodings, FSM state encoding, partial-product shift table and
// operand-half extraction helper.
package cpu_0_mulx_pkg;

    typedef enum logic [1:0] {
        OP_MUL    = 2'b00,
        OP_MULXUU = 2'b01,
        OP_MULXSU = 2'b10,
        OP_MULXSS = 2'b11
    } mulx_op_e;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_ISSUE = 3'd1,
        ST_DRAIN = 3'd2,
        ST_CORR  = 3'd3,
        ST_DONE  = 3'd4
    } mulx_state_e;

    // Index of the last partial product issued for the full and short sequences.
    localparam logic [1:0] LAST_K_FULL  = 2'd3;
    localparam logic [1:0] LAST_K_EARLY = 2'd2;

    // Left shift applied to partial product k: aL*bL, aH*bL, aL*bH, aH*bH.
    function automatic logic [5:0] pp_shift(input logic [1:0] k);
        logic [5:0] sh;
        case (k)
            2'd0:    sh = 6'd0;
            2'd1:    sh = 6'd16;
            2'd2:    sh = 6'd16;
            2'd3:    sh = 6'd32;
            default: sh = 6'd0;
        endcase
        return sh;
    endfunction

    // Zero-extended 16-bit half of a 32-bit operand, as the cell expects it.
    function automatic logic [31:0] half_ext(input logic [31:0] w, input logic hi);
        return hi ? {16'h0000, w[31:16]} : {16'h0000, w[15:0]};
    endfunction

endpackage

// File: rtl/cpu_0_mulx_acc.sv
// 64-bit product accumulator for the multiply sequencer.
// Adds each shifted partial product, and presents the selected result word
// (with the signed high-word correction for MULXSU/MULXSS) computed from the
// accumulator value including any add happening this cycle, so the caller can
// register it on the same edge as the final accumulation.
module cpu_0_mulx_acc
    import cpu_0_mulx_pkg::*;
(
    input  logic        clk,
    input  logic        reset_n,
    input  logic        clear,
    input  logic        add_en,
    input  logic [1:0]  add_idx,
    input  logic [31:0] cell_result,
    input  mulx_op_e    op,
    input  logic [31:0] opa,
    input  logic [31:0] opb,
    output logic [31:0] res_word
);

    logic [63:0] acc_q;
    logic [63:0] acc_d;
    logic [63:0] addend_s;
    logic [63:0] sum_s;
    logic [31:0] corr_s;
    logic [31:0] hi_s;

    // Shift the incoming partial product into place and form the next accumulator value.
    always_comb begin
        addend_s = {32'h0000_0000, cell_result} << pp_shift(add_idx);
        if (add_en) begin
            sum_s = acc_q + addend_s;
        end else begin
            sum_s = acc_q;
        end
        if (clear) begin
            acc_d = 64'h0;
        end else begin
            acc_d = sum_s;
        end
    end

    // Signed correction of the high word: undo the unsigned treatment of negative operands.
    always_comb begin
        case (op)
            OP_MUL:    corr_s = 32'h0;
            OP_MULXUU: corr_s = 32'h0;
            OP_MULXSU: corr_s = opa[31] ? opb : 32'h0;
            OP_MULXSS: corr_s = (opa[31] ? opb : 32'h0) + (opb[31] ? opa : 32'h0);
            default:   corr_s = 32'h0;
        endcase
        hi_s = sum_s[63:32] - corr_s;
        if (op == OP_MUL) begin
            res_word = sum_s[31:0];
        end else begin
            res_word = hi_s;
        end
    end

    // Accumulator register.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            acc_q <= 64'h0;
        end else begin
            acc_q <= acc_d;
        end
    end

endmodule

// File: rtl/cpu_0_mulx_seq.sv
// Multi-cycle sequencer for Nios II MUL / MULXUU / MULXSU / MULXSS.
// Feeds four 16x16 partial products (one per cycle) to an external multiplier
// cell, accumulates the shifted results, applies signed correction and returns
// the selected 32-bit word with a valid/ready handshake.
// Optional feature macro: CPU_0_MULX_EARLY_MUL_EN -- MUL issues only the three
// partial products that reach the low word and skips the correction state.
module cpu_0_mulx_seq
    import cpu_0_mulx_pkg::*;
#(
    parameter int unsigned CELL_LAT = 1
) (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        start_valid,
    output logic        start_ready,
    input  logic [1:0]  op,
    input  logic [31:0] src1,
    input  logic [31:0] src2,
    output logic        result_valid,
    input  logic        result_ready,
    output logic [31:0] result,
    output logic [31:0] mul_src1,
    output logic [31:0] mul_src2,
    input  logic [31:0] mul_cell_result
);

    mulx_state_e state_q;
    mulx_state_e state_d;
    logic [1:0]  k_q;
    logic [1:0]  k_d;
    logic [1:0]  drn_q;
    logic [1:0]  drn_d;
    logic [31:0] a_q;
    logic [31:0] a_d;
    logic [31:0] b_q;
    logic [31:0] b_d;
    mulx_op_e    op_q;
    mulx_op_e    op_d;
    logic [31:0] mul_src1_q;
    logic [31:0] mul_src1_d;
    logic [31:0] mul_src2_q;
    logic [31:0] mul_src2_d;
    logic [31:0] result_q;
    logic [31:0] result_d;
    logic        result_valid_q;
    logic        result_valid_d;

    // Valid/index pipe: one stage per cycle of cell latency.
    logic [CELL_LAT-1:0]       vld_q;
    logic [CELL_LAT-1:0]       vld_d;
    logic [CELL_LAT-1:0][1:0]  idx_q;
    logic [CELL_LAT-1:0][1:0]  idx_d;

    logic        accept_s;
    logic [1:0]  k_nxt_s;
    logic [1:0]  last_k_s;
    logic        skip_corr_s;
    logic        drain_last_s;
    logic        acc_clear_s;
    logic [31:0] res_word_s;

    assign start_ready  = (state_q == ST_IDLE) && reset_n;
    assign accept_s     = start_valid && start_ready;
    assign k_nxt_s      = k_q + 2'd1;
    assign drain_last_s = (drn_q == 2'(CELL_LAT - 1));

`ifdef CPU_0_MULX_EARLY_MUL_EN
    // aH*bH only lands in bits 63:32, so the low-word MUL can stop after k2.
    assign last_k_s    = (op_q == OP_MUL) ? LAST_K_EARLY : LAST_K_FULL;
    assign skip_corr_s = (op_q == OP_MUL);
`else
    assign last_k_s    = LAST_K_FULL;
    assign skip_corr_s = 1'b0;
`endif

    assign result_valid = result_valid_q;
    assign result       = result_q;
    assign mul_src1     = mul_src1_q;
    assign mul_src2     = mul_src2_q;

    // Track which issue cycle each in-flight cell result belongs to.
    always_comb begin
        vld_d    = '0;
        idx_d    = '0;
        vld_d[0] = (state_q == ST_ISSUE);
        idx_d[0] = k_q;
        for (int i = 1; i < int'(CELL_LAT); i++) begin
            vld_d[i] = vld_q[i-1];
            idx_d[i] = idx_q[i-1];
        end
    end

    // FSM next state, operand latching, cell operand muxing and result capture.
    always_comb begin
        state_d        = state_q;
        k_d            = k_q;
        drn_d          = drn_q;
        a_d            = a_q;
        b_d            = b_q;
        op_d           = op_q;
        mul_src1_d     = 32'h0;
        mul_src2_d     = 32'h0;
        result_d       = result_q;
        result_valid_d = result_valid_q;
        acc_clear_s    = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    state_d     = ST_ISSUE;
                    k_d         = 2'd0;
                    a_d         = src1;
                    b_d         = src2;
                    op_d        = mulx_op_e'(op);
                    acc_clear_s = 1'b1;
                    // Operands are registered, so issue k0 is set up on the accept edge.
                    mul_src1_d  = half_ext(src1, 1'b0);
                    mul_src2_d  = half_ext(src2, 1'b0);
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (k_q == last_k_s) begin
                    state_d = ST_DRAIN;
                    drn_d   = 2'd0;
                end else begin
                    k_d        = k_nxt_s;
                    mul_src1_d = half_ext(a_q, k_nxt_s[0]);
                    mul_src2_d = half_ext(b_q, k_nxt_s[1]);
                end
            end
            ST_DRAIN: begin
                if (drain_last_s) begin
                    if (skip_corr_s) begin
                        state_d        = ST_DONE;
                        result_d       = res_word_s;
                        result_valid_d = 1'b1;
                    end else begin
                        state_d = ST_CORR;
                    end
                end else begin
                    drn_d = drn_q + 2'd1;
                end
            end
            ST_CORR: begin
                state_d        = ST_DONE;
                result_d       = res_word_s;
                result_valid_d = 1'b1;
            end
            ST_DONE: begin
                if (result_ready) begin
                    state_d        = ST_IDLE;
                    result_valid_d = 1'b0;
                end else begin
                    state_d        = ST_DONE;
                    result_valid_d = 1'b1;
                end
            end
            default: begin
                state_d        = ST_IDLE;
                result_valid_d = 1'b0;
            end
        endcase
    end

    // State, operand, output and valid-pipe registers; reset flushes everything in flight.
    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q        <= ST_IDLE;
            k_q            <= 2'd0;
            drn_q          <= 2'd0;
            a_q            <= 32'h0;
            b_q            <= 32'h0;
            op_q           <= OP_MUL;
            mul_src1_q     <= 32'h0;
            mul_src2_q     <= 32'h0;
            result_q       <= 32'h0;
            result_valid_q <= 1'b0;
            vld_q          <= '0;
            idx_q          <= '0;
        end else begin
            state_q        <= state_d;
            k_q            <= k_d;
            drn_q          <= drn_d;
            a_q            <= a_d;
            b_q            <= b_d;
            op_q           <= op_d;
            mul_src1_q     <= mul_src1_d;
            mul_src2_q     <= mul_src2_d;
            result_q       <= result_d;
            result_valid_q <= result_valid_d;
            vld_q          <= vld_d;
            idx_q          <= idx_d;
        end
    end

    cpu_0_mulx_acc u_acc (
        .clk         (clk),
        .reset_n     (reset_n),
        .clear       (acc_clear_s),
        .add_en      (vld_q[CELL_LAT-1]),
        .add_idx     (idx_q[CELL_LAT-1]),
        .cell_result (mul_cell_result),
        .op          (op_q),
        .opa         (a_q),
        .opb         (b_q),
        .res_word    (res_word_s)
    );

endmodule

// File: tb/tb_cpu_0_mulx_seq.sv
// Self-checking bench for cpu_0_mulx_seq with a registered 16x16 cell (CELL_LAT=1).
// Expected results are pushed to a scoreboard queue at start and popped when
// the DUT presents a result.
module tb_cpu_0_mulx_seq;

`ifdef CPU_0_MULX_EARLY_MUL_EN
    localparam int MUL_LAT    = 5;
    localparam int MUL_ISSUES = 3;
`else
    localparam int MUL_LAT    = 7;
    localparam int MUL_ISSUES = 4;
`endif
    localparam int MULX_LAT = 7;

    logic        clk = 1'b0;
    logic        reset_n = 1'b0;
    logic        start_valid = 1'b0;
    logic        start_ready;
    logic [1:0]  op = 2'b00;
    logic [31:0] src1 = 32'h0;
    logic [31:0] src2 = 32'h0;
    logic        result_valid;
    logic        result_ready = 1'b0;
    logic [31:0] result;
    logic [31:0] mul_src1;
    logic [31:0] mul_src2;
    logic [31:0] cell_q = 32'h0;

    int checks = 0;
    int errors = 0;
    logic [31:0] sb_q[$];

    always #5 clk = ~clk;

    // Cell model: registered unsigned 16x16 multiply.
    always @(posedge clk) cell_q <= 32'(mul_src1[15:0]) * 32'(mul_src2[15:0]);

    cpu_0_mulx_seq #(.CELL_LAT(1)) dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .start_valid     (start_valid),
        .start_ready     (start_ready),
        .op              (op),
        .src1            (src1),
        .src2            (src2),
        .result_valid    (result_valid),
        .result_ready    (result_ready),
        .result          (result),
        .mul_src1        (mul_src1),
        .mul_src2        (mul_src2),
        .mul_cell_result (cell_q)
    );

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached, checks=%0d", checks);
        $fatal(1, "watchdog");
    end

    // Reference: full-width product of the sign/zero-extended operands.
    function automatic logic [31:0] model(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b);
        logic [63:0] ea;
        logic [63:0] eb;
        logic [63:0] p;
        ea = (o == 2'b10 || o == 2'b11) ? {{32{a[31]}}, a} : {32'h0, a};
        eb = (o == 2'b11) ? {{32{b[31]}}, b} : {32'h0, b};
        p  = ea * eb;
        return (o == 2'b00) ? p[31:0] : p[63:32];
    endfunction

    // Wait for start_ready (bounded), present one operation, push its expectation.
    task automatic start_op(input logic [1:0] o, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] exp_v);
        int n;
        n = 0;
        while (!start_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        checks++;
        if (!start_ready) begin
            errors++;
            $display("FAIL start_wait: start_ready=%0b required 1 within 50 cycles", start_ready);
        end
        op = o; src1 = a; src2 = b; start_valid = 1'b1;
        sb_q.push_back(exp_v);
        @(posedge clk);
        #1;
        start_valid = 1'b0; op = 2'b00; src1 = 32'h0; src2 = 32'h0;
    endtask

    // Count cycles (and nonzero cell issues) after accept until result_valid, bounded.
    task automatic wait_result(output logic [31:0] res, output int lat, output int issues, output bit to);
        lat = 0; issues = 0; to = 1'b1;
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (mul_src1 != 32'h0 || mul_src2 != 32'h0) issues++;
            if (result_valid) begin
                to = 1'b0;
                break;
            end
        end
        res = result;
    endtask

    // Accept the pending result; returns at the negedge of the following cycle.
    task automatic finish_op();
        result_ready = 1'b1;
        @(posedge clk);
        #1;
        result_ready = 1'b0;
        @(negedge clk);
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clk);
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL rst_valid: got %0b want 0", result_valid); end
        checks++; if (result !== 32'h0) begin errors++; $display("FAIL rst_result: got %h want 00000000", result); end
        checks++; if (mul_src1 !== 32'h0) begin errors++; $display("FAIL rst_src1: got %h want 00000000", mul_src1); end
        checks++; if (mul_src2 !== 32'h0) begin errors++; $display("FAIL rst_src2: got %h want 00000000", mul_src2); end
        checks++; if (start_ready !== 1'b0) begin errors++; $display("FAIL rst_ready_low: got %0b want 0", start_ready); end
        reset_n = 1'b1;
        @(negedge clk);
        checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL rst_ready_idle: got %0b want 1", start_ready); end
    endtask

    task automatic test_mulxuu();
        logic [31:0] res;
        logic [31:0] exp_v;
        int lat;
        int iss;
        bit to;
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        wait_result(res, lat, iss, to);
        exp_v = sb_q.pop_front();
        checks++; if (to) begin errors++; $display("FAIL uu_timeout: result_valid=%0b want 1", result_valid); end
        checks++; if (res !== exp_v) begin errors++; $display("FAIL uu_result: got %h want %h", res, exp_v); end
        checks++; if (lat != MULX_LAT) begin errors++; $display("FAIL uu_latency: got %0d want %0d", lat, MULX_LAT); end
        checks++; if (iss != 4) begin errors++; $display("FAIL uu_issues: got %0d want 4", iss); end
        finish_op();
        checks++; if (result_valid !== 1'b0 || start_ready !== 1'b1) begin
            errors++; $display("FAIL uu_release: valid=%0b ready=%0b want 0/1", result_valid, start_ready);
        end
    endtask

    task automatic test_signed();
        logic [1:0]  ops [4] = '{2'b11, 2'b11, 2'b10, 2'b00};
        logic [31:0] as  [4] = '{32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0000, 32'h0001_2345};
        logic [31:0] bs  [4] = '{32'h0000_0002, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 32'h0001_0000};
        logic [31:0] ex  [4] = '{32'hFFFF_FFFF, 32'h3FFF_FFFF, 32'h8000_0000, 32'h2345_0000};
        logic [31:0] res;
        logic [31:0] exp_v;
        int lat;
        int iss;
        bit to;
        for (int t = 0; t < 4; t++) begin
            start_op(ops[t], as[t], bs[t], ex[t]);
            wait_result(res, lat, iss, to);
            exp_v = sb_q.pop_front();
            checks++; if (res !== exp_v) begin errors++; $display("FAIL signed_%0d: got %h want %h", t, res, exp_v); end
            checks++; if (lat != ((ops[t] == 2'b00) ? MUL_LAT : MULX_LAT)) begin
                errors++; $display("FAIL signed_lat_%0d: got %0d want %0d", t, lat, (ops[t] == 2'b00) ? MUL_LAT : MULX_LAT);
            end
            finish_op();
        end
    endtask

    task automatic test_mul_all_ones();
        logic [31:0] res;
        logic [31:0] exp_v;
        int lat;
        int iss;
        bit to;
        start_op(2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0001);
        wait_result(res, lat, iss, to);
        exp_v = sb_q.pop_front();
        checks++; if (res !== exp_v) begin errors++; $display("FAIL mul_ones: got %h want %h", res, exp_v); end
        checks++; if (lat != MUL_LAT) begin errors++; $display("FAIL mul_ones_lat: got %0d want %0d", lat, MUL_LAT); end
        checks++; if (iss != MUL_ISSUES) begin errors++; $display("FAIL mul_ones_issues: got %0d want %0d", iss, MUL_ISSUES); end
        finish_op();
    endtask

    task automatic test_back_to_back();
        logic [31:0] res;
        logic [31:0] exp_v;
        logic [31:0] a;
        logic [31:0] b;
        logic [1:0]  o;
        int lat;
        int iss;
        bit to;
        for (int t = 0; t < 12; t++) begin
            a = $urandom; b = $urandom; o = 2'($urandom_range(0, 3));
            if (t == 0) begin a = 32'h8000_0000; b = 32'h8000_0000; o = 2'b11; end
            start_op(o, a, b, model(o, a, b));
            wait_result(res, lat, iss, to);
            exp_v = sb_q.pop_front();
            checks++; if (res !== exp_v) begin
                errors++; $display("FAIL b2b_%0d: op=%0d a=%h b=%h got %h want %h", t, o, a, b, res, exp_v);
            end
            finish_op();
            checks++; if (start_ready !== 1'b1) begin errors++; $display("FAIL b2b_ready_%0d: got %0b want 1", t, start_ready); end
        end
    endtask

    task automatic test_backpressure();
        logic [31:0] res;
        logic [31:0] exp_v;
        int lat;
        int iss;
        bit to;
        int bad;
        start_op(2'b01, 32'h1234_5678, 32'h9ABC_DEF0, model(2'b01, 32'h1234_5678, 32'h9ABC_DEF0));
        wait_result(res, lat, iss, to);
        exp_v = sb_q.pop_front();
        checks++; if (res !== exp_v) begin errors++; $display("FAIL bp_result: got %h want %h", res, exp_v); end
        bad = 0;
        op = 2'b00; src1 = 32'h0000_0005; src2 = 32'h0000_0007; start_valid = 1'b1;
        for (int c = 0; c < 10; c++) begin
            @(negedge clk);
            if (result_valid !== 1'b1 || result !== exp_v || start_ready !== 1'b0) bad++;
        end
        start_valid = 1'b0; op = 2'b00; src1 = 32'h0; src2 = 32'h0;
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_hold: %0d unstable cycles, want 0", bad); end
        finish_op();
        bad = 0;
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (result_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL bp_ghost: %0d cycles with result_valid, want 0", bad); end
    endtask

    task automatic test_reset_mid();
        logic [31:0] res;
        logic [31:0] exp_v;
        int lat;
        int iss;
        bit to;
        int bad;
        start_op(2'b01, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE);
        repeat (3) @(negedge clk);
        reset_n = 1'b0;
        @(posedge clk);
        #1;
        checks++; if (result_valid !== 1'b0) begin errors++; $display("FAIL mid_valid: got %0b want 0", result_valid); end
        checks++; if (mul_src1 !== 32'h0 || mul_src2 !== 32'h0) begin
            errors++; $display("FAIL mid_src: got %h/%h want 0/0", mul_src1, mul_src2);
        end
        @(negedge clk);
        reset_n = 1'b1;
        sb_q.delete();
        bad = 0;
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            if (result_valid !== 1'b0) bad++;
        end
        checks++; if (bad != 0) begin errors++; $display("FAIL mid_spurious: %0d cycles with result_valid, want 0", bad); end
        start_op(2'b01, 32'h2, 32'h3, 32'h0000_0000);
        wait_result(res, lat, iss, to);
        exp_v = sb_q.pop_front();
        checks++; if (to || res !== exp_v) begin errors++; $display("FAIL mid_uu: got %h want %h", res, exp_v); end
        finish_op();
        start_op(2'b00, 32'h2, 32'h3, 32'h0000_0006);
        wait_result(res, lat, iss, to);
        exp_v = sb_q.pop_front();
        checks++; if (to || res !== exp_v) begin errors++; $display("FAIL mid_mul: got %h want %h", res, exp_v); end
        finish_op();
    endtask

    initial begin
        test_reset();
        test_mulxuu();
        test_signed();
        test_mul_all_ones();
        test_back_to_back();
        test_backpressure();
        test_reset_mid();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
